// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - WB and LU writeback request handshakes into the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;

  modport master (
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - WB/LU register-file write-port arbiter with starvation-forced LU grant.
// Optional grant statistics counters are enabled by defining WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     RD,
  output logic [DATA_W-1:0]     WriteData,
`ifdef WB_ARB_STATS_EN
  output logic [31:0]           stat_wb_grants,
  output logic [31:0]           stat_lu_grants,
  output logic [31:0]           stat_forced,
`endif
  output logic                  lu_forced
);

  typedef enum logic {NORMAL = 1'b0, FORCE_LU = 1'b1} state_t;

  localparam logic [7:0] CNT_MAX = 8'(STARVE_LIMIT - 1);

  state_t            state_q, state_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              lu_forced_q, lu_forced_d;

  logic same_rd;
  logic wb_rdy, lu_rdy;
  logic wb_xfer, lu_xfer, lu_denied;

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_wb_q, stat_wb_d;
  logic [31:0] stat_lu_q, stat_lu_d;
  logic [31:0] stat_forced_q, stat_forced_d;
`endif

  // Same nonzero rd: LU is older, so it goes first and WB lands last.
  always_comb begin
    same_rd = (bus.wb_rd == bus.lu_rd) && (bus.wb_rd != '0);
    wb_rdy  = 1'b0;
    lu_rdy  = 1'b1;
    if (state_q == NORMAL) begin
      wb_rdy = !(bus.wb_valid && bus.lu_valid && same_rd);
      lu_rdy = !bus.wb_valid || same_rd;
    end
  end

  assign bus.wb_ready = wb_rdy;
  assign bus.lu_ready = lu_rdy;

  always_comb begin
    wb_xfer   = bus.wb_valid && wb_rdy;
    lu_xfer   = bus.lu_valid && lu_rdy;
    lu_denied = bus.lu_valid && !lu_rdy;

    state_d = NORMAL;
    if (state_q == NORMAL && lu_denied && starve_cnt_q == CNT_MAX) begin
      state_d = FORCE_LU;
    end

    starve_cnt_d = starve_cnt_q;
    if (!bus.lu_valid || lu_xfer) begin
      starve_cnt_d = '0;
    end else if (lu_denied && starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    reg_write_d  = (wb_xfer && bus.wb_rd != '0) || (lu_xfer && bus.lu_rd != '0);
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (lu_xfer) begin
      rd_d         = bus.lu_rd;
      write_data_d = bus.lu_data;
    end else if (wb_xfer) begin
      rd_d         = bus.wb_rd;
      write_data_d = bus.wb_data;
    end

    lu_forced_d = (state_d == FORCE_LU);

`ifdef WB_ARB_STATS_EN
    stat_wb_d     = stat_wb_q + {31'd0, wb_xfer};
    stat_lu_d     = stat_lu_q + {31'd0, lu_xfer};
    stat_forced_d = stat_forced_q + {31'd0, (state_q == NORMAL) && (state_d == FORCE_LU)};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      lu_forced_q  <= 1'b0;
`ifdef WB_ARB_STATS_EN
      stat_wb_q     <= '0;
      stat_lu_q     <= '0;
      stat_forced_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      lu_forced_q  <= lu_forced_d;
`ifdef WB_ARB_STATS_EN
      stat_wb_q     <= stat_wb_d;
      stat_lu_q     <= stat_lu_d;
      stat_forced_q <= stat_forced_d;
`endif
    end
  end

  assign RegWrite  = reg_write_q;
  assign RD        = rd_q;
  assign WriteData = write_data_q;
  assign lu_forced = lu_forced_q;

`ifdef WB_ARB_STATS_EN
  assign stat_wb_grants = stat_wb_q;
  assign stat_lu_grants = stat_lu_q;
  assign stat_forced    = stat_forced_q;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - the in-order pipeline WB stage;
  - the long-latency unit (LU): multi-cycle multiply/divide and load-miss return.
- Arbitrates with valid/ready handshakes and registers the winning write onto RegWrite/RD/WriteData.
- A starvation counter forces an LU grant, stalling WB, so LU results cannot be blocked indefinitely.

Parameters:
- DATA_W, 64, writeback data width.
- ADDR_W, 5, register index width.
- STARVE_LIMIT, 4, consecutive denied LU cycles before a forced LU grant; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  1  WB stage has a result.
- wb_rd  input  ADDR_W  WB destination register.
- wb_data  input  DATA_W  WB result.
- wb_ready  output  1  WB request accepted this cycle (combinational).
- lu_valid  input  1  LU has a result.
- lu_rd  input  ADDR_W  LU destination register.
- lu_data  input  DATA_W  LU result.
- lu_ready  output  1  LU request accepted this cycle (combinational).
- RegWrite  output  1  register-file write enable (registered).
- RD  output  ADDR_W  register-file write index (registered).
- WriteData  output  DATA_W  register-file write data (registered).
- lu_forced  output  1  high while state is FORCE_LU (registered, status).

Behaviour:
- Reset values:
  - RegWrite=0, RD=0, WriteData=0, lu_forced=0.
  - state=NORMAL, starve_cnt=0.
- Handshake:
  - A transfer occurs when valid && ready at a posedge.
  - Sources hold valid/rd/data stable until accepted.
  - Ready never depends on ready.
- State NORMAL, fixed priority to WB:
  - wb_ready = !(wb_valid && lu_valid && wb_rd==lu_rd && wb_rd!=0).
  - lu_ready = !wb_valid || (wb_rd==lu_rd && wb_rd!=0).
- Same-rd collision with both valid: LU (older) is granted first and WB is granted the next cycle. This gives correct program order: WB result lands last.
- State FORCE_LU:
  - lu_ready=1, wb_ready=0.
  - Returns to NORMAL on the next posedge, whether or not lu_valid is still high.
- starve_cnt:
  - Increments when lu_valid && !lu_ready in NORMAL.
  - Clears on an LU transfer or when lu_valid=0.
  - Saturates at STARVE_LIMIT-1.
- Transition NORMAL->FORCE_LU when lu_valid && !lu_ready && starve_cnt==STARVE_LIMIT-1. The forced grant therefore occurs after exactly STARVE_LIMIT denied cycles.
- Output register, one-cycle latency:
  - A transfer accepted at edge N drives RegWrite=1, RD, WriteData for cycle N..N+1; the register file writes at edge N+1.
  - With no transfer, RegWrite=0 and RD/WriteData hold their last values.
- Writes to x0: a transfer with rd==0 is accepted normally, but RegWrite stays 0 for it.
- At most one transfer per cycle. Throughput is one write per cycle.
- Reset asserted mid-operation:
  - Outputs return to reset values on that edge.
  - Any request presented that cycle is not accepted.
  - A pending forced grant is dropped.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - Adds output ports stat_wb_grants[31:0], stat_lu_grants[31:0] and stat_forced[31:0].
  - These count WB transfers, LU transfers and FORCE_LU entries.
  - All counters clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single WB write: wb_valid=1, wb_rd=3, wb_data=64'hA5 for one cycle -> wb_ready=1; next cycle RegWrite=1, RD=3, WriteData=64'hA5; cycle after that RegWrite=0.
- Concurrent, different rd: WB rd=4, LU rd=7, both valid -> WB accepted first, LU accepted next cycle; writes to x4 then x7 on consecutive cycles.
- Same-rd collision: WB rd=5 data=1, LU rd=5 data=2, both valid -> LU written first, WB second; the register file reads x5=1 afterwards.
- Starvation with STARVE_LIMIT=4: wb_valid held 1 and lu_valid=1 from cycle 0 -> lu_ready=0 for 4 cycles, lu_forced=1 and lu_ready=1, wb_ready=0 in cycle 4, NORMAL again in cycle 5.
- x0 write: lu_valid=1, lu_rd=0, lu_data=64'hFF -> lu_ready=1, RegWrite stays 0; with WB_ARB_STATS_EN, stat_lu_grants increments by 1.
- Reset mid-burst: reset=1 while both sources valid and starve_cnt=2 -> both readies are don't-care that cycle with no transfer; next cycle RegWrite=0, lu_forced=0, starve_cnt=0 (no forced grant after 2 further denials).
